// File: rtl/seq_shift_add_mult_if.sv
// Operand/product handshake bundle for seq_shift_add_mult.
// signed_op exists only when SEQMUL_SIGNED_EN is defined.
interface seq_shift_add_mult_if #(
    parameter int unsigned WIDTH = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;
`ifdef SEQMUL_SIGNED_EN
    logic               signed_op;
`endif

    modport master (
        output in_valid, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product, busy
`ifdef SEQMUL_SIGNED_EN
        , output signed_op
`endif
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product, busy
`ifdef SEQMUL_SIGNED_EN
        , input signed_op
`endif
    );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Radix-2 sequential shift-add multiplier, one add/shift step per cycle.
// Optional two's-complement mode enabled by defining SEQMUL_SIGNED_EN.
module seq_shift_add_mult #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_shift_add_mult_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplr_q;
    logic [WIDTH:0]   acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]    product_q;
`ifdef SEQMUL_SIGNED_EN
    logic             neg_q;
`endif

    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic             neg_c;
    logic [WIDTH:0]   sum_c;
    logic [PW-1:0]    raw_c;
    logic [PW-1:0]    result_c;

    // Operand conditioning at accept, step adder, and the final-step product.
    // acc MSB is zero after every shift, so adding the full acc equals adding its low WIDTH bits.
    always_comb begin
        a_mag_c  = bus.multiplicand;
        b_mag_c  = bus.multiplier;
        neg_c    = 1'b0;
`ifdef SEQMUL_SIGNED_EN
        if (bus.signed_op) begin
            if (bus.multiplicand[WIDTH-1]) a_mag_c = ~bus.multiplicand + WIDTH'(1);
            if (bus.multiplier[WIDTH-1])   b_mag_c = ~bus.multiplier + WIDTH'(1);
            neg_c = bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
        end
`endif
        sum_c    = acc_q + (mplr_q[0] ? {1'b0, mcand_q} : '0);
        raw_c    = {sum_c, mplr_q[WIDTH-1:1]};
        result_c = raw_c;
`ifdef SEQMUL_SIGNED_EN
        if (neg_q) result_c = ~raw_c + PW'(1);
`endif
    end

    // Controller and datapath in one registered process.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef SEQMUL_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        mcand_q <= a_mag_c;
                        mplr_q  <= b_mag_c;
                        acc_q   <= '0;
                        cnt_q   <= '0;
`ifdef SEQMUL_SIGNED_EN
                        neg_q   <= neg_c;
`endif
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_q  <= {1'b0, sum_c[WIDTH:1]};
                    mplr_q <= {sum_c[0], mplr_q[WIDTH-1:1]};
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        product_q <= result_c;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Status decodes straight from the state register.
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.product   = product_q;

`ifndef SEQMUL_SIGNED_EN
    logic unused_c;
    assign unused_c = neg_c;
`endif
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult: WIDTH=16 and WIDTH=8 instances.
module tb_seq_shift_add_mult;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] p;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] q16[$];
    logic [15:0] q8[$];
    int          t8[$];

    seq_shift_add_mult_if #(.WIDTH(16)) b16 ();
    seq_shift_add_mult_if #(.WIDTH(8))  b8 ();

    seq_shift_add_mult #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(b16));
    seq_shift_add_mult #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Scoreboard monitors: product compared on the cycle before the handshake edge.
    always @(negedge clk) begin
        if (!reset && b16.out_valid && b16.out_ready) begin
            if (q16.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out16: got 0x%0h expected none", b16.product);
            end else check("product16", 64'(b16.product), 64'(q16.pop_front()));
        end
        if (!reset && b8.out_valid && b8.out_ready) begin
            t8.push_back(cyc);
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out8: got 0x%0h expected none", b8.product);
            end else check("product8", 64'(b8.product), 64'(q8.pop_front()));
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
        bit acc = 0;
        int n   = 0;
        b16.in_valid = 1'b1; b16.multiplicand = a; b16.multiplier = b;
        while (!acc && n < 100) begin
            @(negedge clk); acc = b16.in_ready; n++;
            @(posedge clk); #1;
        end
        b16.in_valid = 1'b0;
        b16.multiplicand = 16'($urandom); b16.multiplier = 16'($urandom);
        if (acc) q16.push_back(exp); else fail("accept16");
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        bit acc = 0;
        int n   = 0;
        b8.in_valid = 1'b1; b8.multiplicand = a; b8.multiplier = b;
        while (!acc && n < 100) begin
            @(negedge clk); acc = b8.in_ready; n++;
            @(posedge clk); #1;
        end
        b8.in_valid = 1'b0;
        b8.multiplicand = 8'($urandom); b8.multiplier = 8'($urandom);
        if (acc) q8.push_back(exp); else fail("accept8");
    endtask

    task automatic wait16_empty();
        int n = 0;
        while (q16.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        if (q16.size() != 0) begin fail("drain16"); q16.delete(); end
    endtask

    task automatic wait8_empty();
        int n = 0;
        while (q8.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        if (q8.size() != 0) begin fail("drain8"); q8.delete(); end
    endtask

    initial begin
        int first;
        int n;

        vecs.push_back('{16'h0003, 16'h0005, 1'b0, 32'h0000000F});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001});
        vecs.push_back('{16'h0000, 16'hABCD, 1'b0, 32'h00000000});
        vecs.push_back('{16'hABCD, 16'h0000, 1'b0, 32'h00000000});
        vecs.push_back('{16'h1234, 16'h0100, 1'b0, 32'h00123400});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF});
        vecs.push_back('{16'h8000, 16'h0002, 1'b0, 32'h00010000});
        vecs.push_back('{16'hABCD, 16'h0003, 1'b0, 32'h00020367});
        vecs.push_back('{16'h00FF, 16'h0100, 1'b0, 32'h0000FF00});
        vecs.push_back('{16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE});
`ifdef SEQMUL_SIGNED_EN
        vecs.push_back('{16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB});
        vecs.push_back('{16'h8000, 16'h8000, 1'b1, 32'h40000000});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001});
        vecs.push_back('{16'h0005, 16'hFFFE, 1'b1, 32'hFFFFFFF6});
`endif

        reset = 1'b1;
        b16.in_valid = 1'b0; b16.multiplicand = '0; b16.multiplier = '0; b16.out_ready = 1'b1;
        b8.in_valid  = 1'b0; b8.multiplicand  = '0; b8.multiplier  = '0; b8.out_ready  = 1'b1;
`ifdef SEQMUL_SIGNED_EN
        b16.signed_op = 1'b0; b8.signed_op = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready16", 64'(b16.in_ready), 64'd1);
        check("rst_out_valid16", 64'(b16.out_valid), 64'd0);
        check("rst_busy16", 64'(b16.busy), 64'd0);
        check("rst_product16", 64'(b16.product), 64'd0);
        check("rst_in_ready8", 64'(b8.in_ready), 64'd1);
        check("rst_product8", 64'(b8.product), 64'd0);
        @(posedge clk); #1; reset = 1'b0;

        // Latency and in_ready/busy profile for 3*5.
        send16(16'h0003, 16'h0005, 32'h0000000F);
        first = 0;
        for (int c = 1; c <= 40 && first == 0; c++) begin
            @(negedge clk);
            if (c <= 17) begin
                check("calc_in_ready16", 64'(b16.in_ready), 64'd0);
                check("calc_busy16", 64'(b16.busy), 64'd1);
            end
            if (b16.out_valid) first = c;
        end
        check("latency16", 64'(first), 64'd17);
        @(negedge clk);
        check("post_in_ready16", 64'(b16.in_ready), 64'd1);
        check("post_out_valid16", 64'(b16.out_valid), 64'd0);
        @(posedge clk); #1;
        wait16_empty();

        // Table-driven vectors through the scoreboard.
        foreach (vecs[i]) begin
`ifdef SEQMUL_SIGNED_EN
            b16.signed_op = vecs[i].s;
`endif
            send16(vecs[i].a, vecs[i].b, vecs[i].p);
            wait16_empty();
        end
`ifdef SEQMUL_SIGNED_EN
        b16.signed_op = 1'b0;
`endif

        // Backpressure: product held, in_valid ignored in DONE.
        b16.out_ready = 1'b0;
        send16(16'h1234, 16'h0100, 32'h00123400);
        n = 0;
        do begin @(negedge clk); n++; end while (!b16.out_valid && n < 40);
        check("bp_out_valid", 64'(b16.out_valid), 64'd1);
        @(posedge clk); #1;
        b16.in_valid = 1'b1; b16.multiplicand = 16'h0002; b16.multiplier = 16'h0003;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_product", 64'(b16.product), 64'h00123400);
            check("bp_hold_valid", 64'(b16.out_valid), 64'd1);
            check("bp_in_ready", 64'(b16.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        b16.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_idle_in_ready", 64'(b16.in_ready), 64'd1);
        check("bp_idle_out_valid", 64'(b16.out_valid), 64'd0);
        check("bp_retained", 64'(b16.product), 64'h00123400);
        q16.push_back(32'h00000006);
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        @(negedge clk);
        check("bp_new_accept", 64'(b16.busy), 64'd1);
        @(posedge clk); #1;
        wait16_empty();

        // Reset in cycle 8 of CALC discards the partial result.
        send16(16'h00FF, 16'h00FF, 32'h0000FE01);
        repeat (7) @(posedge clk);
        #1;
        check("mid_busy", 64'(b16.busy), 64'd1);
        reset = 1'b1;
        #1;
        check("abort_in_ready", 64'(b16.in_ready), 64'd1);
        check("abort_out_valid", 64'(b16.out_valid), 64'd0);
        check("abort_busy", 64'(b16.busy), 64'd0);
        check("abort_product", 64'(b16.product), 64'd0);
        q16.delete();
        @(posedge clk); #1; reset = 1'b0;
        send16(16'd7, 16'd9, 32'd63);
        wait16_empty();

        // WIDTH=8: latency then back-to-back throughput.
        send8(8'hFF, 8'hFF, 16'hFE01);
        first = 0;
        for (int c = 1; c <= 30 && first == 0; c++) begin
            @(negedge clk);
            if (b8.out_valid) first = c;
        end
        check("latency8", 64'(first), 64'd9);
        @(posedge clk); #1;
        wait8_empty();
        t8.delete();
        send8(8'd5, 8'd6, 16'd30);
        send8(8'h80, 8'h80, 16'h4000);
        send8(8'h12, 8'h34, 16'h03A8);
        wait8_empty();
        check("b2b_count8", 64'(t8.size()), 64'd3);
        if (t8.size() == 3) begin
            check("b2b_period8_a", 64'(t8[1] - t8[0]), 64'd10);
            check("b2b_period8_b", 64'(t8[2] - t8[1]), 64'd10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
